// File: rtl/axi_rt_isolate_ctrl.sv
// axi_rt_isolate_ctrl: isolation sequencer for one AXI address channel (AW or AR).
// When the budget runs out or software asks for isolation, new address
// handshakes are gated, outstanding transactions drain, and the port is then
// reported isolated. The port is released on the next period reload. The
// block also counts outstanding transactions and throttles at NumPending.
module axi_rt_isolate_ctrl #(
  parameter int unsigned NumPending = 16,
  parameter int unsigned CntWidth   = $clog2(NumPending + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                budget_spent_i,
  input  logic                period_over_i,
  input  logic                isolate_req_i,
  input  logic                ax_valid_i,
  input  logic                ax_ready_i,
  input  logic                resp_done_i,
  output logic                gate_o,
  output logic                isolated_o,
  output logic [CntWidth-1:0] pending_o,
  output logic                underflow_o
);

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StDrain    = 2'd1,
    StIsolated = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] pending_q, pending_d;
  logic                underflow_q, underflow_d;

  logic ax_fire;
  logic stalled;
  logic release_req;
  logic at_capacity;

  // Outputs come from registers only, so no input reaches gate_o combinationally.
  assign at_capacity = (pending_q == CntWidth'(NumPending));
  assign gate_o      = (state_q != StRun) | at_capacity;
  assign isolated_o  = (state_q == StIsolated);
  assign pending_o   = pending_q;
  assign underflow_o = underflow_q;

  assign ax_fire     = ax_valid_i & ax_ready_i & ~gate_o;
  // A valid already offered downstream must not be withdrawn by gating.
  assign stalled     = ax_valid_i & ~ax_ready_i & ~gate_o;
  assign release_req = period_over_i & ~isolate_req_i;

  // Outstanding-transaction counter and sticky underflow flag.
  always_comb begin
    pending_d   = pending_q;
    underflow_d = underflow_q;
    if (ax_fire && !resp_done_i) begin
      pending_d = pending_q + CntWidth'(1);
    end else if (resp_done_i && !ax_fire) begin
      if (pending_q == '0) begin
        pending_d   = '0;
        underflow_d = 1'b1;
      end else begin
        pending_d = pending_q - CntWidth'(1);
      end
    end else begin
      pending_d = pending_q;
    end
  end

  // Isolation sequencing: RUN -> DRAIN -> ISOLATED -> RUN on period reload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (enable_i && (budget_spent_i || isolate_req_i) && !stalled) begin
          state_d = StDrain;
        end else begin
          state_d = StRun;
        end
      end
      StDrain: begin
        if (!enable_i) begin
          state_d = StRun;
        end else if (release_req) begin
          state_d = StRun;
        end else if (pending_q == '0) begin
          state_d = StIsolated;
        end else begin
          state_d = StDrain;
        end
      end
      StIsolated: begin
        if (!enable_i) begin
          state_d = StRun;
        end else if (release_req) begin
          state_d = StRun;
        end else begin
          state_d = StIsolated;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State, counter and flag registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      pending_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_axi_rt_isolate_ctrl.sv
// Directed testbench for axi_rt_isolate_ctrl (NumPending = 4).
module tb_axi_rt_isolate_ctrl;

  localparam int unsigned NP = 4;
  localparam int unsigned CW = $clog2(NP + 1);

  logic          clk_i;
  logic          rst_ni;
  logic          enable_i;
  logic          budget_spent_i;
  logic          period_over_i;
  logic          isolate_req_i;
  logic          ax_valid_i;
  logic          ax_ready_i;
  logic          resp_done_i;
  logic          gate_o;
  logic          isolated_o;
  logic [CW-1:0] pending_o;
  logic          underflow_o;

  int n_cmp;
  int n_err;

  axi_rt_isolate_ctrl #(.NumPending(NP)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .budget_spent_i (budget_spent_i),
    .period_over_i  (period_over_i),
    .isolate_req_i  (isolate_req_i),
    .ax_valid_i     (ax_valid_i),
    .ax_ready_i     (ax_ready_i),
    .resp_done_i    (resp_done_i),
    .gate_o         (gate_o),
    .isolated_o     (isolated_o),
    .pending_o      (pending_o),
    .underflow_o    (underflow_o)
  );

  // Free-running clock, 10 time-unit period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 1 unit past the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input int g, input int iso, input int p, input int u);
    chk({tag, ".gate"}, int'(gate_o), g);
    chk({tag, ".iso"},  int'(isolated_o), iso);
    chk({tag, ".pend"}, int'(pending_o), p);
    chk({tag, ".unf"},  int'(underflow_o), u);
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst_ni         = 1'b0;
    enable_i       = 1'b1;
    budget_spent_i = 1'b0;
    period_over_i  = 1'b0;
    isolate_req_i  = 1'b0;
    ax_valid_i     = 1'b0;
    ax_ready_i     = 1'b0;
    resp_done_i    = 1'b0;

    // Reset
    #12;
    rst_ni = 1'b1;
    cyc(1);
    chk_all("reset", 0, 0, 0, 0);

    // Three fires, budget exhausted, drain to isolation
    ax_valid_i = 1'b1; ax_ready_i = 1'b1;
    cyc(3);
    chk("t1.fire3", int'(pending_o), 3);
    ax_valid_i = 1'b0; ax_ready_i = 1'b0; budget_spent_i = 1'b1;
    cyc(1);
    chk_all("t1.gated", 1, 0, 3, 0);
    resp_done_i = 1'b1;
    cyc(1);
    chk("t1.p2", int'(pending_o), 2);
    cyc(1);
    chk("t1.p1", int'(pending_o), 1);
    cyc(1);
    chk_all("t1.p0", 1, 0, 0, 0);
    resp_done_i = 1'b0;
    cyc(1);
    chk_all("t1.iso", 1, 1, 0, 0);

    // Isolated with software request held across two reloads
    budget_spent_i = 1'b0; isolate_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      period_over_i = 1'b1;
      cyc(1);
      period_over_i = 1'b0;
      cyc(1);
      chk("t4.hold.iso", int'(isolated_o), 1);
      chk("t4.hold.gate", int'(gate_o), 1);
    end
    isolate_req_i = 1'b0; period_over_i = 1'b1;
    cyc(1);
    period_over_i = 1'b0;
    chk_all("t4.release", 0, 0, 0, 0);

    // Trigger while a handshake is stalled: transition deferred
    ax_valid_i = 1'b1; ax_ready_i = 1'b0; budget_spent_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("t2.stall.gate", int'(gate_o), 0);
    end
    ax_ready_i = 1'b1;
    cyc(1);
    chk_all("t2.fired", 1, 0, 1, 0);
    ax_valid_i = 1'b0; ax_ready_i = 1'b0;

    // Release from DRAIN, then re-drain with pending 2 and release again
    budget_spent_i = 1'b0; period_over_i = 1'b1;
    cyc(1);
    period_over_i = 1'b0;
    chk_all("t5.rel1", 0, 0, 1, 0);
    ax_valid_i = 1'b1; ax_ready_i = 1'b1;
    cyc(1);
    ax_valid_i = 1'b0; ax_ready_i = 1'b0; isolate_req_i = 1'b1;
    cyc(1);
    chk_all("t5.drain2", 1, 0, 2, 0);
    isolate_req_i = 1'b0; period_over_i = 1'b1;
    cyc(1);
    period_over_i = 1'b0;
    chk_all("t5.rel2", 0, 0, 2, 0);

    // Capacity throttle at NumPending
    ax_valid_i = 1'b1; ax_ready_i = 1'b1;
    cyc(2);
    chk_all("t3.full", 1, 0, 4, 0);
    cyc(1);
    chk("t3.full.hold", int'(pending_o), 4);
    ax_valid_i = 1'b0; ax_ready_i = 1'b0; resp_done_i = 1'b1;
    cyc(1);
    chk_all("t3.p3", 0, 0, 3, 0);
    ax_valid_i = 1'b1; ax_ready_i = 1'b1;
    cyc(2);
    chk_all("t3.both", 0, 0, 3, 0);
    ax_valid_i = 1'b0; ax_ready_i = 1'b0;

    // Drain to zero, then underflow
    cyc(3);
    chk_all("t6.zero", 0, 0, 0, 0);
    cyc(1);
    chk_all("t6.unf", 0, 0, 0, 1);
    resp_done_i = 1'b0;
    cyc(2);
    chk("t6.unf.sticky", int'(underflow_o), 1);

    // Enable drop while isolated
    isolate_req_i = 1'b1;
    cyc(2);
    chk("t7.iso", int'(isolated_o), 1);
    enable_i = 1'b0;
    cyc(1);
    chk_all("t7.run", 0, 0, 0, 1);
    cyc(1);
    chk("t7.run.hold", int'(gate_o), 0);

    // Asynchronous reset mid-DRAIN
    enable_i = 1'b1; isolate_req_i = 1'b0;
    ax_valid_i = 1'b1; ax_ready_i = 1'b1;
    cyc(1);
    ax_valid_i = 1'b0; ax_ready_i = 1'b0; budget_spent_i = 1'b1;
    cyc(1);
    chk_all("t8.drain", 1, 0, 1, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_all("t8.async", 0, 0, 0, 0);
    budget_spent_i = 1'b0; resp_done_i = 1'b1;
    rst_ni = 1'b1;
    cyc(1);
    resp_done_i = 1'b0;
    chk_all("t8.inflight", 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rt_isolate_ctrl.md
Name: axi_rt_isolate_ctrl

Overview:
- Sequences isolation of one AXI manager port (one address channel: AW or AR) from the budget/period counter unit of the RT unit.
- When the budget is exhausted or software requests isolation, it gates new address handshakes, drains outstanding transactions, then reports the port isolated.
- It releases the port on the next period reload.
- Also tracks outstanding transactions and throttles the port at a fixed maximum.

Parameters:
- NumPending, 16, maximum outstanding transactions tracked; must be >= 1.
- CntWidth, $clog2(NumPending+1), width of the pending counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  RT enforcement enable; 0 forces the RUN state
- budget_spent_i  in  1  budget exhausted, level, from the counter unit
- period_over_i  in  1  one-cycle pulse: period expired and budget reloaded
- isolate_req_i  in  1  software isolation request, level
- ax_valid_i  in  1  manager-side address valid (ungated)
- ax_ready_i  in  1  subordinate-side address ready
- resp_done_i  in  1  final response handshake of one transaction (B, or R with last)
- gate_o  out  1  1 = block the address channel (valid and ready forced 0 outside this block)
- isolated_o  out  1  port fully drained and isolated
- pending_o  out  CntWidth  outstanding transaction count
- underflow_o  out  1  sticky: resp_done_i seen with pending_o == 0

Behaviour:
- Reset values: state RUN, pending_o = 0, underflow_o = 0, gate_o = 0, isolated_o = 0.
- Definitions:
  - ax_fire = ax_valid_i & ax_ready_i & !gate_o.
  - stalled = ax_valid_i & !ax_ready_i & !gate_o (a handshake offered downstream but not yet accepted).
- Pending counter, registered, updates one cycle after the event:
  - ax_fire only: +1.
  - resp_done_i only: -1.
  - Both in the same cycle: unchanged.
  - resp_done_i alone at 0: count stays 0 and underflow_o sets.
  - underflow_o clears only on reset.
- gate_o = (state != RUN) | (pending_o == NumPending).
  - Combinational from registers only; no combinational path from any input.
  - The capacity term rises only in the cycle after a fire, so no downstream valid is ever withdrawn.
- FSM states: RUN, DRAIN, ISOLATED.
- RUN:
  - Goes to DRAIN when enable_i & (budget_spent_i | isolate_req_i) & !stalled.
  - While stalled, the transition is deferred until the handshake completes; this preserves AXI valid stability.
  - period_over_i is ignored in RUN.
- DRAIN:
  - Goes to ISOLATED when pending_o == 0. Counter state is the registered value; a response arriving this cycle is counted first.
  - Goes to RUN instead if period_over_i & !isolate_req_i. If that coincides with drain completion, RUN wins.
- ISOLATED:
  - Goes to RUN on period_over_i & !isolate_req_i.
  - With isolate_req_i held, stays ISOLATED across period reloads.
- enable_i = 0 in DRAIN or ISOLATED: next state is RUN, with priority over all other transitions.
- RUN with budget still spent after release: if budget_spent_i remains 1 (budget configured 0), the block re-enters DRAIN next cycle. This is legal.
- isolated_o = (state == ISOLATED), registered state decode.
- Latency:
  - Trigger to gate_o = 1: one cycle.
  - period_over_i to gate_o = 0: one cycle.
- pending_o keeps counting in all states, since responses drain while gated.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). Responses still in flight then decrement from 0, so underflow_o sets. This is documented, expected behaviour after a reset with traffic in flight.

Test Plan:
- Three AR fires, enable_i = 1, budget_spent_i rises -> gate_o = 1 next cycle. After three resp_done_i pulses, pending_o reads 3, 2, 1, 0, then isolated_o = 1 one cycle after pending_o reaches 0.
- budget_spent_i rises while ax_valid_i = 1 and ax_ready_i = 0 for 4 cycles -> gate_o stays 0 until ax_ready_i = 1. The fire is counted (pending_o = 1), then gate_o = 1 on the following cycle.
- NumPending = 4, 4 back-to-back fires -> gate_o = 1 with pending_o = 4. One resp_done_i -> pending_o = 3 and gate_o = 0 next cycle. Simultaneous fire and resp_done_i -> pending_o unchanged.
- ISOLATED with isolate_req_i = 1, two period_over_i pulses -> remains isolated. Drop isolate_req_i, then pulse period_over_i -> RUN, gate_o = 0 and isolated_o = 0 next cycle.
- In DRAIN with pending_o = 2, pulse period_over_i (budget_spent_i low) -> RUN next cycle, gate_o = 0, pending_o still 2.
- resp_done_i at pending_o = 0 -> underflow_o = 1 and stays 1. Deassert enable_i in ISOLATED -> RUN next cycle. Assert rst_ni low mid-DRAIN -> all outputs 0 asynchronously.
